// File: rtl/hamming_frame_rx.sv
// hamming_frame_rx: framed Hamming(12,8) serial receiver with a
// one-deep valid/ready output register.
//
// Ports:
//   clk, rst            clock, async active-high reset
//   bit_valid, bit_in   sliced bit strobe and value
//   out_data            decoded byte
//   out_valid/ready     output handshake
//   out_corrected       single-bit error was fixed
//   out_uncorr          uncorrectable syndrome, raw data
//   frame_err           pulse: stop bit was 0
//   overrun             pulse: frame dropped, output full
//
// Build option: HAMMING_RX_CORRECT_EN enables single-bit
// correction; without it the block only detects errors.
module hamming_frame_rx (
    input  logic       clk,
    input  logic       rst,
    input  logic       bit_valid,
    input  logic       bit_in,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_corrected,
    output logic       out_uncorr,
    output logic       frame_err,
    output logic       overrun
);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        STOP
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [11:0] sr_q, sr_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        corr_q, corr_d;
    logic        unc_q, unc_d;
    logic        ferr_q, ferr_d;
    logic        ovr_q, ovr_d;

    logic [7:0]  rx_d;
    logic [3:0]  rx_p;
    logic [3:0]  pc;
    logic [3:0]  syn;
    logic [7:0]  dec_data;
    logic        dec_corr;
    logic        dec_unc;

    // Decode straight from the shift register; it is stable
    // while the FSM waits in STOP for the stop bit.
    assign rx_d = sr_q[11:4];
    assign rx_p = sr_q[3:0];

    assign pc[3] = rx_d[7] ^ rx_d[6] ^ rx_d[5] ^ rx_d[1];
    assign pc[2] = rx_d[7] ^ rx_d[4] ^ rx_d[3] ^ rx_d[1] ^ rx_d[0];
    assign pc[1] = rx_d[6] ^ rx_d[4] ^ rx_d[2] ^ rx_d[1] ^ rx_d[0];
    assign pc[0] = rx_d[5] ^ rx_d[3] ^ rx_d[2] ^ rx_d[0];

    assign syn = pc ^ rx_p;

`ifdef HAMMING_RX_CORRECT_EN
    logic [7:0] fix;

    always_comb begin
        fix      = 8'h00;
        dec_corr = 1'b0;
        dec_unc  = 1'b0;
        case (syn)
            4'b0000: ;
            4'b1100: fix = 8'h80;
            4'b1010: fix = 8'h40;
            4'b1001: fix = 8'h20;
            4'b0110: fix = 8'h10;
            4'b0101: fix = 8'h08;
            4'b0011: fix = 8'h04;
            4'b1110: fix = 8'h02;
            4'b0111: fix = 8'h01;
            // Parity bit hit: data is already correct.
            4'b1000, 4'b0100,
            4'b0010, 4'b0001: dec_corr = 1'b1;
            default: dec_unc = 1'b1;
        endcase
        if (fix != 8'h00) begin
            dec_corr = 1'b1;
        end
        dec_data = rx_d ^ fix;
    end
`else
    always_comb begin
        dec_data = rx_d;
        dec_corr = 1'b0;
        dec_unc  = |syn;
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        data_d  = data_q;
        valid_d = valid_q;
        corr_d  = corr_q;
        unc_d   = unc_q;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;

        // A handshake empties the register unless a new
        // frame lands in the same cycle (handled below).
        if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end

        if (bit_valid) begin
            unique case (state_q)
                IDLE: begin
                    if (!bit_in) begin
                        cnt_d   = 4'd0;
                        state_d = DATA;
                    end
                end
                DATA: begin
                    sr_d = {sr_q[10:0], bit_in};
                    if (cnt_q == 4'd11) begin
                        state_d = STOP;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                STOP: begin
                    state_d = IDLE;
                    if (!bit_in) begin
                        ferr_d = 1'b1;
                    end else if (!valid_q || out_ready) begin
                        data_d  = dec_data;
                        corr_d  = dec_corr;
                        unc_d   = dec_unc;
                        valid_d = 1'b1;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            sr_q    <= 12'h000;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            corr_q  <= 1'b0;
            unc_q   <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            corr_q  <= corr_d;
            unc_q   <= unc_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign out_data      = data_q;
    assign out_valid     = valid_q;
    assign out_corrected = corr_q;
    assign out_uncorr    = unc_q;
    assign frame_err     = ferr_q;
    assign overrun       = ovr_q;

endmodule

// File: tb/tb_hamming_frame_rx.sv
// tb_hamming_frame_rx: scoreboard bench for hamming_frame_rx.
// Expected bytes are queued at stimulus time, popped on handshake.
module tb_hamming_frame_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       bit_valid;
    logic       bit_in;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_corrected;
    logic       out_uncorr;
    logic       frame_err;
    logic       overrun;

    int total = 0;
    int bad   = 0;
    int ferr_cnt = 0;
    int ovr_cnt  = 0;
    logic [9:0] sb[$];

    hamming_frame_rx dut (
        .clk          (clk),
        .rst          (rst),
        .bit_valid    (bit_valid),
        .bit_in       (bit_in),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_corrected(out_corrected),
        .out_uncorr   (out_uncorr),
        .frame_err    (frame_err),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic c,
                        input logic u);
        sb.push_back({d, c, u});
    endtask

    // Called at posedge+1; holds bit_valid across adjacent strobes.
    task automatic strobe(input logic b);
        bit_valid = 1'b1;
        bit_in    = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [11:0] cw, input logic stopb,
                              input int rdy);
        strobe(1'b0);
        for (int i = 11; i >= 0; i--) strobe(cw[i]);
        if (rdy >= 0) out_ready = rdy[0];
        strobe(stopb);
        bit_valid = 1'b0;
        bit_in    = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: pulse counting and scoreboard compare on handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_err) ferr_cnt++;
            if (overrun) ovr_cnt++;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out act=%0h exp=none",
                             out_data);
                end else begin
                    logic [9:0] e;
                    e = sb.pop_front();
                    chk("out_data", {24'd0, out_data}, {24'd0, e[9:2]});
                    chk("out_corrected", {31'd0, out_corrected},
                        {31'd0, e[1]});
                    chk("out_uncorr", {31'd0, out_uncorr},
                        {31'd0, e[0]});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        bit_valid = 1'b0;
        bit_in    = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data", {24'd0, out_data}, 32'h00);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_corr", {31'd0, out_corrected}, 32'd0);
        chk("rst_uncorr", {31'd0, out_uncorr}, 32'd0);
        chk("rst_ferr", {31'd0, frame_err}, 32'd0);
        chk("rst_ovr", {31'd0, overrun}, 32'd0);
        rst = 1'b0;
        idle(2);

        // Clean byte, plus latency of out_valid.
        push(8'hA5, 1'b0, 1'b0);
        send_frame(12'hA51, 1'b1, 1);
        chk("lat_valid", {31'd0, out_valid}, 32'd1);
        idle(2);

        // d5 flipped.
`ifdef HAMMING_RX_CORRECT_EN
        push(8'hA5, 1'b1, 1'b0);
`else
        push(8'h85, 1'b0, 1'b1);
`endif
        send_frame(12'h851, 1'b1, 1);
        idle(2);

        // p0 flipped: data untouched.
`ifdef HAMMING_RX_CORRECT_EN
        push(8'hA5, 1'b1, 1'b0);
`else
        push(8'hA5, 1'b0, 1'b1);
`endif
        send_frame(12'hA50, 1'b1, 1);
        idle(2);

        // d0 flipped (A5 -> A4, syndrome 0111).
`ifdef HAMMING_RX_CORRECT_EN
        push(8'hA5, 1'b1, 1'b0);
`else
        push(8'hA4, 1'b0, 1'b1);
`endif
        send_frame(12'hA41, 1'b1, 1);
        idle(2);

        // Syndrome 1101: uncorrectable in both builds.
        push(8'h25, 1'b0, 1'b1);
        send_frame(12'h250, 1'b1, 1);
        idle(2);

        // Bad stop bit.
        send_frame(12'hA51, 1'b0, 1);
        chk("ferr_valid", {31'd0, out_valid}, 32'd0);
        idle(3);
        chk("ferr_pulse", ferr_cnt, 1);
        chk("ferr_valid2", {31'd0, out_valid}, 32'd0);
        push(8'hA5, 1'b0, 1'b0);
        send_frame(12'hA51, 1'b1, 1);
        idle(2);

        // Back-to-back, sink stalled: second frame overruns.
        out_ready = 1'b0;
        push(8'hA5, 1'b0, 1'b0);
        send_frame(12'hA51, 1'b1, -1);
        send_frame(12'h000, 1'b1, -1);
        idle(3);
        chk("ovr_pulse", ovr_cnt, 1);
        chk("ovr_hold_valid", {31'd0, out_valid}, 32'd1);
        chk("ovr_hold_data", {24'd0, out_data}, 32'hA5);
        out_ready = 1'b1;
        idle(2);
        chk("ovr_drain", {31'd0, out_valid}, 32'd0);

        // Back-to-back, sink ready on the second stop strobe.
        out_ready = 1'b0;
        push(8'hA5, 1'b0, 1'b0);
        push(8'h00, 1'b0, 1'b0);
        send_frame(12'hA51, 1'b1, -1);
        send_frame(12'h000, 1'b1, 1);
        idle(3);
        chk("no_ovr", ovr_cnt, 1);
        chk("b2b_empty", sb.size(), 0);

        // Reset mid-frame with a byte held in the register.
        out_ready = 1'b0;
        push(8'h00, 1'b0, 1'b0);
        send_frame(12'h000, 1'b1, -1);
        strobe(1'b0);
        for (int i = 0; i < 6; i++) strobe(1'b1);
        bit_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_data", {24'd0, out_data}, 32'h00);
        sb.delete();
        idle(2);
        rst = 1'b0;
        out_ready = 1'b1;
        idle(1);
        push(8'hA5, 1'b0, 1'b0);
        send_frame(12'hA51, 1'b1, 1);
        idle(3);

        chk("sb_empty", sb.size(), 0);
        chk("ferr_total", ferr_cnt, 1);
        chk("ovr_total", ovr_cnt, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hamming_frame_rx.md
# hamming_frame_rx

Serial receive-side block for the FSK link. It takes the demodulated bit stream, delineates start/stop-framed 12-bit Hamming(12,8) codewords and checks each codeword's syndrome. Single-bit errors are corrected, and the byte is delivered through a one-deep valid/ready output register. It sits between the FSK demodulator's bit slicer and the byte sink. It is the far end of the transmit path that Hamming-encodes bytes and serialises them.

## Interface
Parameters: none; codeword and frame format are fixed.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- bit_valid  in  1  one-cycle strobe: bit_in is a new sliced bit
- bit_in  in  1  demodulated bit, sampled only when bit_valid=1
- out_data  out  8  decoded (corrected) byte
- out_valid  out  1  out_data and flags are held valid
- out_ready  in  1  sink accepts; transfer when out_valid & out_ready
- out_corrected  out  1  a single-bit error was corrected in this byte
- out_uncorr  out  1  uncorrectable syndrome; out_data is the raw data field
- frame_err  out  1  one-cycle pulse: stop bit was 0, frame dropped
- overrun  out  1  one-cycle pulse: completed frame dropped, output register full

## Operation
- Frame format, one bit per bit_valid strobe:
  - start bit 0
  - codeword bits c[11] down to c[0], MSB first
  - stop bit 1
- Codeword layout is c = {d[7:0], p[3:0]}, with:
  - p3 = d7^d6^d5^d1
  - p2 = d7^d4^d3^d1^d0
  - p1 = d6^d4^d2^d1^d0
  - p0 = d5^d3^d2^d0
- Syndrome s[i] = recomputed p[i] XOR received p[i].
- Syndrome to flipped bit:
  - data bits: 1100→d7, 1010→d6, 1001→d5, 0110→d4, 0101→d3, 0011→d2, 1110→d1, 0111→d0
  - parity bits: 1000→p3, 0100→p2, 0010→p1, 0001→p0
- Flag rules by syndrome:
  - 0000: corrected=0, uncorr=0.
  - Any data- or parity-bit syndrome: corrected=1. A parity-bit syndrome leaves the data unchanged but still sets corrected.
  - 1011, 1101, 1111: uncorr=1, data passed raw.
- FSM states IDLE, DATA, STOP:
  - IDLE: on a strobe with bit_in=0, clear the bit counter and go to DATA. A strobe with bit_in=1 (idle line) is ignored.
  - DATA: shift bit_in into a 12-bit shift register on each strobe. After the 12th bit (counter 11), go to STOP.
  - STOP: on a strobe with bit_in=1, complete the frame. On a strobe with bit_in=0, pulse frame_err and discard the frame. Either way, return to IDLE.
- Frame completion:
  - If the output register is empty, or out_ready=1 in the same cycle, load data and flags and set out_valid.
  - Otherwise keep the old contents, pulse overrun and discard the new frame.
- Output register: out_valid, out_data and the flags stay stable until the handshake. Handshake with no completion in that cycle clears out_valid.
- Cycles without bit_valid never change FSM or shift state.

## Timing
- Reset values: out_data=0x00, out_valid=0, out_corrected=0, out_uncorr=0, frame_err=0, overrun=0, FSM=IDLE, counter=0.
- Latency: out_valid rises on the clock edge that samples the stop-bit strobe, i.e. it is visible in the cycle after that strobe. Decode is combinational from the shift register in that cycle.
- frame_err and overrun are registered one-cycle pulses, asserted the cycle after the offending stop strobe.
- Back-to-back frames are supported: a start bit may be the strobe immediately after the stop bit.
- Reset asserted mid-frame discards the partial frame and any held output immediately (asynchronous).
- bit_valid strobes may be adjacent every cycle; the minimum frame time is 14 cycles.

## Configuration
- HAMMING_RX_CORRECT_EN defined:
  - syndrome correction as in Operation
  - out_corrected as specified
- HAMMING_RX_CORRECT_EN undefined (detection only):
  - out_data is always the raw d field
  - any nonzero syndrome sets out_uncorr=1
  - out_corrected is tied 0

## Test plan
- Byte 0xA5 sent as codeword 0xA51 with start/stop, out_ready=1 → out_data=0xA5, corrected=0, uncorr=0, out_valid one cycle after stop strobe.
- Codeword 0x851 (d5 flipped) → out_data=0xA5, corrected=1. With the macro undefined → out_data=0x85, uncorr=1.
- Codeword 0x250 (d7 and p0 flipped, syndrome 1101) → out_data=0x25, uncorr=1, corrected=0.
- Frame with stop bit 0 → frame_err one-cycle pulse, out_valid stays 0, next valid frame decodes correctly.
- Two back-to-back frames 0xA51 then 0x000 with out_ready=0 → first byte 0xA5 held, overrun pulse on second stop. Repeat with out_ready=1 on the second stop cycle → 0x00 loaded, no overrun.
- rst asserted after 6 codeword bits → all outputs at reset values. Then a full 0xA51 frame → 0xA5.
